// File: rtl/spi_shift_engine.sv
// SPI shift engine: serialises a parallel word onto mosi_o and deserialises miso_i,
// advancing on launch/sample strobes from the baud generator.
module spi_shift_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned LEN_W = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  PCLK,
  input  logic                  PRESET_i,
  input  logic                  ss_i,
  input  logic                  send_data_i,
  input  logic                  lsbfe_i,
  input  logic                  cpha_i,
  input  logic                  cpol_i,
  input  logic [LEN_W-1:0]      frame_len_i,
  input  logic                  miso_recieve_sclk_i,
  input  logic                  miso_recieve_sclk0_i,
  input  logic                  mosi_send_sclk_i,
  input  logic                  mosi_send_sclk0_i,
  input  logic [DATA_WIDTH-1:0] data_mosi_i,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [DATA_WIDTH-1:0] data_miso_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  abort_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_word_q, tx_word_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] data_miso_q, data_miso_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [LEN_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic                  lsbfe_q, lsbfe_d;
  logic                  cpha_q, cpha_d;
  logic                  cpol_q, cpol_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;

  logic [LEN_W-1:0]      eff_len_c;
  logic [LEN_W-1:0]      tx_next_c;
  logic [LEN_W-1:0]      rx_idx_c;
  logic                  sample_c;
  logic                  launch_c;
  logic                  load_bit_c;
  logic                  tx_bit_c;

  // Word index of frame bit k for the given order and length.
  function automatic logic [LEN_W-1:0] word_idx(input logic lsbfe, input logic [LEN_W-1:0] len,
                                                input logic [LEN_W-1:0] k);
    return lsbfe ? k : LEN_W'(len - k - LEN_W'(1));
  endfunction

  function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] word, input logic [LEN_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (LEN_W'(i) == idx) b = word[i];
    end
    return b;
  endfunction

  assign eff_len_c  = (frame_len_i == '0 || frame_len_i > MAX_LEN) ? MAX_LEN : frame_len_i;
  assign sample_c   = (cpol_q ^ cpha_q) ? miso_recieve_sclk0_i : miso_recieve_sclk_i;
  assign launch_c   = (cpol_q ^ cpha_q) ? mosi_send_sclk0_i : mosi_send_sclk_i;
  // cpha=0 has bit 0 already on the line after load, so each launch drives the following bit.
  assign tx_next_c  = cpha_q ? tx_cnt_q : LEN_W'(tx_cnt_q + LEN_W'(1));
  assign rx_idx_c   = word_idx(lsbfe_q, len_q, rx_cnt_q);
  assign load_bit_c = pick_bit(data_mosi_i, word_idx(lsbfe_i, eff_len_c, '0));
  assign tx_bit_c   = pick_bit(tx_word_q, word_idx(lsbfe_q, len_q, tx_next_c));

  always_ff @(posedge PCLK or negedge PRESET_i) begin
    if (!PRESET_i) begin
      state_q     <= ST_IDLE;
      tx_word_q   <= '0;
      rx_q        <= '0;
      data_miso_q <= '0;
      len_q       <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      lsbfe_q     <= 1'b0;
      cpha_q      <= 1'b0;
      cpol_q      <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_word_q   <= tx_word_d;
      rx_q        <= rx_d;
      data_miso_q <= data_miso_d;
      len_q       <= len_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      lsbfe_q     <= lsbfe_d;
      cpha_q      <= cpha_d;
      cpol_q      <= cpol_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_word_d   = tx_word_q;
    rx_d        = rx_q;
    data_miso_d = data_miso_q;
    len_d       = len_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    lsbfe_d     = lsbfe_q;
    cpha_d      = cpha_q;
    cpol_d      = cpol_q;
    mosi_d      = mosi_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (send_data_i && !ss_i) begin
          tx_word_d = data_mosi_i;
          lsbfe_d   = lsbfe_i;
          cpha_d    = cpha_i;
          cpol_d    = cpol_i;
          len_d     = eff_len_c;
          rx_d      = '0;
          tx_cnt_d  = '0;
          rx_cnt_d  = '0;
          if (!cpha_i) mosi_d = load_bit_c;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_i) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (launch_c && tx_next_c < len_q) begin
            mosi_d   = tx_bit_c;
            tx_cnt_d = LEN_W'(tx_cnt_q + LEN_W'(1));
          end
          if (sample_c) begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
              if (LEN_W'(i) == rx_idx_c) rx_d[i] = miso_i;
            end
            rx_cnt_d = LEN_W'(rx_cnt_q + LEN_W'(1));
            // Publish the word together with done so both are visible in the DONE cycle.
            if (rx_cnt_q == LEN_W'(len_q - LEN_W'(1))) begin
              data_miso_d = rx_d;
              done_d      = 1'b1;
              state_d     = ST_DONE;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SHIFT);
  end

  assign mosi_o      = mosi_q;
  assign data_miso_o = data_miso_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign abort_o     = abort_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: an 8-bit and a 16-bit instance share stimulus;
// expected events and mosi bits are queued by the stimulus and popped by a monitor.
module tb_spi_shift_engine;

  logic        clk;
  logic        rst_n;
  logic        ss, send, lsbfe, cpha, cpol;
  logic [4:0]  flen;
  logic        rs, rs0, ms, ms0;
  logic [15:0] data;
  logic        miso_bit, loop_en, samp_evt;
  logic        mosi8, mosi16, busy8, busy16, done8, done16, abort8, abort16;
  logic [7:0]  rx8;
  logic [15:0] rx16;
  logic        miso8, miso16;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] ev_q[2][$];
  logic        mo_q[2][$];
  logic [15:0] last_rx[2];

  assign miso8  = loop_en ? mosi8  : miso_bit;
  assign miso16 = loop_en ? mosi16 : miso_bit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_shift_engine #(.DATA_WIDTH(8)) u_dut8 (
    .PCLK(clk), .PRESET_i(rst_n), .ss_i(ss), .send_data_i(send), .lsbfe_i(lsbfe),
    .cpha_i(cpha), .cpol_i(cpol), .frame_len_i(flen[3:0]),
    .miso_recieve_sclk_i(rs), .miso_recieve_sclk0_i(rs0),
    .mosi_send_sclk_i(ms), .mosi_send_sclk0_i(ms0),
    .data_mosi_i(data[7:0]), .miso_i(miso8), .mosi_o(mosi8), .data_miso_o(rx8),
    .busy_o(busy8), .done_o(done8), .abort_o(abort8));

  spi_shift_engine #(.DATA_WIDTH(16)) u_dut16 (
    .PCLK(clk), .PRESET_i(rst_n), .ss_i(ss), .send_data_i(send), .lsbfe_i(lsbfe),
    .cpha_i(cpha), .cpol_i(cpol), .frame_len_i(flen),
    .miso_recieve_sclk_i(rs), .miso_recieve_sclk0_i(rs0),
    .mosi_send_sclk_i(ms), .mosi_send_sclk0_i(ms0),
    .data_mosi_i(data), .miso_i(miso16), .mosi_o(mosi16), .data_miso_o(rx16),
    .busy_o(busy16), .done_o(done16), .abort_o(abort16));

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: events carry {kind[17:16], data[15:0]}, kind 1 = done, 2 = abort.
  always @(negedge clk) begin : monitor
    logic dn, ab, bz, mo, m;
    logic [15:0] rx;
    logic [31:0] e;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        dn = (d == 1) ? done16  : done8;
        ab = (d == 1) ? abort16 : abort8;
        bz = (d == 1) ? busy16  : busy8;
        mo = (d == 1) ? mosi16  : mosi8;
        rx = (d == 1) ? rx16    : {8'h00, rx8};
        if (dn || ab) begin
          if (ev_q[d].size() == 0) begin
            check($sformatf("dut%0d_unexpected_event", d), {30'b0, ab, dn}, 32'h0);
          end else begin
            e = ev_q[d].pop_front();
            check($sformatf("dut%0d_event_kind", d), {30'b0, ab, dn}, {30'b0, e[17:16]});
            check($sformatf("dut%0d_data_miso", d), {16'b0, rx}, {16'b0, e[15:0]});
            check($sformatf("dut%0d_busy_at_event", d), {31'b0, bz}, 32'h0);
          end
        end
        if (samp_evt && mo_q[d].size() != 0) begin
          m = mo_q[d].pop_front();
          check($sformatf("dut%0d_mosi", d), {31'b0, mo}, {31'b0, m});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe_cycle(input logic smp, input logic lnc, input logic sel, input logic noise);
    rs  = (smp && !sel) || (noise && sel);
    rs0 = (smp && sel)  || (noise && !sel);
    ms  = (lnc && !sel) || (noise && sel);
    ms0 = (lnc && sel)  || (noise && !sel);
    samp_evt = smp;
    tick();
    rs = 1'b0; rs0 = 1'b0; ms = 1'b0; ms0 = 1'b0; samp_evt = 1'b0;
  endtask

  // pat bit k is the miso value for frame bit k; exp8/exp16 are the hand-computed rx words.
  task automatic run_frame(input logic [15:0] tx, input logic [4:0] fl, input logic pol,
                           input logic pha, input logic lsb, input logic [15:0] pat,
                           input int abort_at, input int extra, input logic merge,
                           input logic loop, input logic noise,
                           input logic [15:0] exp8, input logic [15:0] exp16);
    int len[2];
    int nb, kk;
    logic sel;
    logic [15:0] word[2];
    logic [15:0] expv[2];
    len[0]  = (fl[3:0] == 4'd0 || fl[3:0] > 4'd8) ? 8 : int'(fl[3:0]);
    len[1]  = (fl == 5'd0 || fl > 5'd16) ? 16 : int'(fl);
    word[0] = {8'h00, tx[7:0]};
    word[1] = tx;
    expv[0] = exp8;
    expv[1] = exp16;
    nb  = ((len[0] > len[1]) ? len[0] : len[1]) + extra;
    sel = pol ^ pha;
    for (int d = 0; d < 2; d++) begin
      if (abort_at >= 0) ev_q[d].push_back({14'h0, 2'b10, last_rx[d]});
      else begin
        ev_q[d].push_back({14'h0, 2'b01, expv[d]});
        last_rx[d] = expv[d];
      end
    end
    ss = 1'b0; send = 1'b1; data = tx; flen = fl; cpol = pol; cpha = pha; lsbfe = lsb;
    loop_en = loop;
    tick();
    // Scramble every captured input; the running frame must not notice.
    send = 1'b0; data = ~tx; flen = 5'd3; cpol = ~pol; cpha = ~pha; lsbfe = ~lsb;
    check("dut8_busy_after_load", {31'b0, busy8}, 32'h1);
    check("dut16_busy_after_load", {31'b0, busy16}, 32'h1);
    for (int k = 0; k < nb; k++) begin
      if (k == abort_at) begin
        ss = 1'b1;
        tick();
        ss = 1'b0;
        break;
      end
      if (pha) strobe_cycle(1'b0, 1'b1, sel, noise);
      for (int d = 0; d < 2; d++) begin
        kk = (k < len[d]) ? k : len[d] - 1;
        mo_q[d].push_back(word[d][lsb ? kk : len[d] - 1 - kk]);
      end
      miso_bit = (k < 16) ? pat[k] : 1'b0;
      strobe_cycle(1'b1, !pha && merge, sel, noise);
      if (!pha && !merge) strobe_cycle(1'b0, 1'b1, sel, noise);
    end
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ss = 1'b1; send = 1'b0; lsbfe = 1'b0; cpha = 1'b0; cpol = 1'b0;
    flen = 5'd0; rs = 1'b0; rs0 = 1'b0; ms = 1'b0; ms0 = 1'b0; data = 16'h0;
    miso_bit = 1'b0; loop_en = 1'b0; samp_evt = 1'b0;
    last_rx[0] = 16'h0; last_rx[1] = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_mosi",  {30'b0, mosi8, mosi16}, 32'h0);
    check("rst_data8", {24'b0, rx8}, 32'h0);
    check("rst_data16", {16'b0, rx16}, 32'h0);
    check("rst_busy",  {30'b0, busy8, busy16}, 32'h0);
    check("rst_done_abort", {28'b0, done8, done16, abort8, abort16}, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    ss = 1'b0;
    tick();

    // T1: mode 0, MSB first, same-cycle sample+launch; mosi 1,0,1,1,0,1,1,0 -> AA
    run_frame(16'h5AB6, 5'd8, 1'b0, 1'b0, 1'b0, 16'h0055, -1, 0, 1'b1, 1'b0, 1'b0, 16'h00AA, 16'h00AA);
    // T4: abort after 3 samples, data_miso stays AA
    run_frame(16'h5AB6, 5'd8, 1'b0, 1'b0, 1'b0, 16'h00FF, 3, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    // T2: cpha=1, LSB first; mosi 0,1,1,0,1,1,0,1 -> 03
    run_frame(16'h5AB6, 5'd8, 1'b0, 1'b1, 1'b1, 16'h0003, -1, 0, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0003);
    // T3: L=4, MSB first, extra strobes after the frame; mosi 0,1,1,0 -> 09
    run_frame(16'h5AB6, 5'd4, 1'b1, 1'b1, 1'b0, 16'h0009, -1, 4, 1'b0, 1'b0, 1'b0, 16'h0009, 16'h0009);
    // T6: frame_len 0 (full width), loopback, all modes, unused strobes toggling
    run_frame(16'hA5C3, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0, -1, 0, 1'b0, 1'b1, 1'b1, 16'h00C3, 16'hA5C3);
    run_frame(16'hA5C3, 5'd0, 1'b0, 1'b1, 1'b1, 16'h0, -1, 0, 1'b0, 1'b1, 1'b1, 16'h00C3, 16'hA5C3);
    run_frame(16'hA5C3, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0, -1, 0, 1'b0, 1'b1, 1'b1, 16'h00C3, 16'hA5C3);
    run_frame(16'hA5C3, 5'd0, 1'b1, 1'b1, 1'b1, 16'h0, -1, 0, 1'b0, 1'b1, 1'b1, 16'h00C3, 16'hA5C3);

    // T5: asynchronous reset mid-frame, between clock edges
    loop_en = 1'b0; ss = 1'b0; send = 1'b1; data = 16'h5AB6; flen = 5'd8;
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    tick();
    send = 1'b0;
    strobe_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mosi",  {30'b0, mosi8, mosi16}, 32'h0);
    check("midrst_data8", {24'b0, rx8}, 32'h0);
    check("midrst_data16", {16'b0, rx16}, 32'h0);
    check("midrst_busy",  {30'b0, busy8, busy16}, 32'h0);
    check("midrst_done_abort", {28'b0, done8, done16, abort8, abort16}, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    last_rx[0] = 16'h0; last_rx[1] = 16'h0;
    tick();
    check("post_rst_idle", {30'b0, busy8, busy16}, 32'h0);
    run_frame(16'h5AB6, 5'd8, 1'b0, 1'b0, 1'b0, 16'h0055, -1, 0, 1'b0, 1'b0, 1'b0, 16'h00AA, 16'h00AA);

    for (int i = 0; i < 20 && (ev_q[0].size() + ev_q[1].size()) > 0; i++) tick();
    check("dut8_pending_events",  ev_q[0].size(), 32'h0);
    check("dut16_pending_events", ev_q[1].size(), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
